mem_copy_master: RTL and testbench

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

---
 rtl/mem_copy_master.sv | 178 +++++++++++++++++
 tb/tb_mem_copy_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// mem_copy_master
// ---------------
// Byte-at-a-time memory copy engine. It drives a single-port memory with a
// registered read. Each byte takes three cycles:
//   READ    - present the source address with write disabled
//   CAPTURE - the memory's registered read data is valid; latch it
//   WRITE   - present the destination address and the latched byte, write enabled
// Bytes are copied in strictly ascending order. Source and destination
// addresses wrap modulo 2^N.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   rstn         : asynchronous active-low reset
//   start        : one-cycle copy request, honoured only while idle
//   abort        : cancels a copy in progress (READ/CAPTURE/WRITE only)
//   src_base     : first source byte address
//   dst_base     : first destination byte address
//   length       : number of bytes to copy (0 is legal and writes nothing)
//   busy         : high in READ, CAPTURE and WRITE
//   done         : one-cycle pulse on normal completion
//   aborted      : one-cycle pulse after an abort
//   count        : bytes written so far in the current/last copy
//   mem_write_en : memory write enable
//   mem_addr     : memory address
//   mem_datain   : memory write data, the byte zero-extended to N bits
//   mem_dataout  : memory registered read data (N/2 bits)

module mem_copy_master #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           abort,
  input  logic [N-1:0]   src_base,
  input  logic [N-1:0]   dst_base,
  input  logic [N-1:0]   length,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic [N-1:0]   count,
  output logic           mem_write_en,
  output logic [N-1:0]   mem_addr,
  output logic [N-1:0]   mem_datain,
  input  logic [N/2-1:0] mem_dataout
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t         state_reg;
  logic [N-1:0]   src_reg;
  logic [N-1:0]   dst_reg;
  logic [N-1:0]   len_reg;
  logic [N-1:0]   count_reg;
  logic [N-1:0]   addr_reg;
  logic [N/2-1:0] byte_reg;
  logic           we_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           aborted_reg;

  // The write for the current byte is already registered when WRITE begins.
  // An abort in that same cycle has to cancel it, so the enable is gated
  // combinationally by abort. Outside WRITE, we_reg is low anyway.
  assign mem_write_en = we_reg & ~abort;

  // Write data is always derived from the byte register. It therefore holds
  // its last value while idle and reads as zero out of reset.
  assign mem_datain   = {{(N - N/2){1'b0}}, byte_reg};

  assign mem_addr     = addr_reg;
  assign count        = count_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign aborted      = aborted_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      src_reg     <= '0;
      dst_reg     <= '0;
      len_reg     <= '0;
      count_reg   <= '0;
      addr_reg    <= '0;
      byte_reg    <= '0;
      we_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      // Pulses and the write strobe default low. Each state re-asserts
      // them only on the transition that needs them.
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      we_reg      <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          // abort is ignored here, so start wins if both are high.
          if (start) begin
            src_reg   <= src_base;
            dst_reg   <= dst_base;
            len_reg   <= length;
            count_reg <= '0;
            if (length == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_READ;
              busy_reg  <= 1'b1;
              addr_reg  <= src_base;
            end
          end
        end

        ST_READ: begin
          if (abort) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
          end else begin
            state_reg <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (abort) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
          end else begin
            // Read data for the address presented in READ is valid now.
            byte_reg  <= mem_dataout;
            addr_reg  <= dst_reg + count_reg;
            we_reg    <= 1'b1;
            state_reg <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (abort) begin
            // The write was suppressed, so count still equals the number
            // of bytes actually written.
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
          end else begin
            count_reg <= count_reg + N'(1);
            if (count_reg + N'(1) == len_reg) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_READ;
              addr_reg  <= src_reg + count_reg + N'(1);
            end
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_master.sv
module tb_mem_copy_master;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic           start;
  logic           abort;
  logic [N-1:0]   src_base;
  logic [N-1:0]   dst_base;
  logic [N-1:0]   length;
  logic           busy;
  logic           done;
  logic           aborted;
  logic [N-1:0]   count;
  logic           mem_write_en;
  logic [N-1:0]   mem_addr;
  logic [N-1:0]   mem_datain;
  logic [N/2-1:0] mem_dataout;

  int checks = 0;
  int fails  = 0;

  mem_copy_master #(.N(N)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .abort        (abort),
    .src_base     (src_base),
    .dst_base     (dst_base),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .count        (count),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_datain   (mem_datain),
    .mem_dataout  (mem_dataout)
  );

  always #5 clk = ~clk;

  // Byte memory with registered read, plus a preload port and a write log.
  logic [7:0]  mem [0:65535];
  logic        pl_en   = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [15:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  logic [31:0] wr_total   = '0;
  logic        prev_we    = 1'b0;
  int          consec_err = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_write_en) begin
      mem[mem_addr]           <= mem_datain[7:0];
      wr_addr[wr_total[5:0]]  <= mem_addr;
      wr_data[wr_total[5:0]]  <= mem_datain[7:0];
      wr_total                <= wr_total + 1;
    end
    mem_dataout <= mem[mem_addr];
    prev_we     <= mem_write_en;
    if (prev_we && mem_write_en) consec_err <= consec_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drives start for one edge (edge 0). Returns 1 time unit after edge 0,
  // i.e. at the start of cycle 1.
  task automatic do_start(input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic ab);
    @(negedge clk);
    start = 1'b1; abort = ab; src_base = s; dst_base = d; length = l;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  // Counts negedges from cycle c0 until done is seen; cyc=-1 on timeout.
  task automatic wait_done(input int c0, output int cyc, output bit busy_seen);
    cyc = c0; busy_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_seen = 1'b1;
      if (done) return;
    end
    cyc = -1;
  endtask

  initial begin
    int          cyc;
    bit          bsy;
    logic [31:0] base;

    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; length = '0;

    repeat (2) @(posedge clk); #1;
    check("rst_busy",    busy,         0);
    check("rst_done",    done,         0);
    check("rst_aborted", aborted,      0);
    check("rst_count",   count,        0);
    check("rst_we",      mem_write_en, 0);
    check("rst_addr",    mem_addr,     0);
    check("rst_datain",  mem_datain,   0);
    @(negedge clk); rstn = 1'b1;

    // Basic two-byte copy: 4,5 -> 100,101.
    poke(16'd4, 8'd1); poke(16'd5, 8'd2);
    base = wr_total;
    do_start(16'd4, 16'd100, 16'd2, 1'b0);
    @(negedge clk);
    check("c1_busy", busy, 1);
    check("c1_addr", mem_addr, 16'd4);
    check("c1_we",   mem_write_en, 0);
    wait_done(1, cyc, bsy);
    check("basic_done_cycle", cyc, 7);
    check("basic_count", count, 2);
    check("basic_busy_at_done", busy, 0);
    check("basic_nwr", wr_total - base, 2);
    check("basic_wr0_addr", wr_addr[base[5:0]], 16'd100);
    check("basic_wr0_data", wr_data[base[5:0]], 8'd1);
    check("basic_wr1_addr", wr_addr[base[5:0] + 6'd1], 16'd101);
    check("basic_wr1_data", wr_data[base[5:0] + 6'd1], 8'd2);
    @(negedge clk);
    check("basic_done_one_cycle", done, 0);
    check("basic_hold_addr", mem_addr, 16'd101);
    check("basic_hold_count", count, 2);
    $display("copy src=4 dst=100 len=2 done_cycle=%0d count=%0d", cyc, count);

    // Zero length, also with abort high alongside start (start wins).
    base = wr_total;
    do_start(16'd7, 16'd8, 16'd0, 1'b1);
    wait_done(0, cyc, bsy);
    check("len0_done_cycle", cyc, 1);
    check("len0_busy_seen", bsy, 0);
    check("len0_count", count, 0);
    check("len0_aborted", aborted, 0);
    repeat (3) @(negedge clk);
    check("len0_nwr", wr_total - base, 0);
    $display("copy len=0 done_cycle=%0d", cyc);

    // Address wrap on the source side.
    poke(16'hFFFF, 8'hAB); poke(16'h0000, 8'hCD);
    base = wr_total;
    do_start(16'hFFFF, 16'h0010, 16'd2, 1'b0);
    wait_done(0, cyc, bsy);
    check("wrap_done_cycle", cyc, 7);
    check("wrap_wr0_addr", wr_addr[base[5:0]], 16'h0010);
    check("wrap_wr0_data", wr_data[base[5:0]], 8'hAB);
    check("wrap_wr1_addr", wr_addr[base[5:0] + 6'd1], 16'h0011);
    check("wrap_wr1_data", wr_data[base[5:0] + 6'd1], 8'hCD);
    $display("copy src=FFFF dst=0010 len=2 done_cycle=%0d", cyc);

    // Abort in CAPTURE of the second byte (cycle 5).
    poke(16'h0200, 8'h11); poke(16'h0201, 8'h22);
    poke(16'h0202, 8'h33); poke(16'h0203, 8'h44);
    poke(16'h0301, 8'hEE);
    base = wr_total;
    do_start(16'h0200, 16'h0300, 16'd4, 1'b0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abrt_pulse", aborted, 1);
    check("abrt_busy", busy, 0);
    check("abrt_count", count, 1);
    check("abrt_done", done, 0);
    @(negedge clk);
    check("abrt_one_cycle", aborted, 0);
    repeat (6) @(negedge clk);
    check("abrt_nwr", wr_total - base, 1);
    check("abrt_wr0_addr", wr_addr[base[5:0]], 16'h0300);
    check("abrt_wr0_data", wr_data[base[5:0]], 8'h11);
    check("abrt_dst1_untouched", mem[16'h0301], 8'hEE);
    $display("abort in CAPTURE byte 1: count=%0d writes=%0d", count, wr_total - base);

    // Abort during WRITE of the first byte (cycle 3) suppresses that write.
    poke(16'h0380, 8'h5A);
    base = wr_total;
    do_start(16'h0200, 16'h0380, 16'd2, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    #1;
    check("abrtw_we_gated", mem_write_en, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abrtw_pulse", aborted, 1);
    check("abrtw_count", count, 0);
    check("abrtw_nwr", wr_total - base, 0);
    check("abrtw_dst_untouched", mem[16'h0380], 8'h5A);
    $display("abort in WRITE byte 0: count=%0d writes=%0d", count, wr_total - base);

    // A second start while busy is ignored.
    poke(16'h0040, 8'hA1); poke(16'h0041, 8'hA2); poke(16'h0042, 8'hA3);
    base = wr_total;
    do_start(16'h0040, 16'h0050, 16'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; src_base = 16'h0000; dst_base = 16'h0900; length = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, cyc, bsy);
    check("restart_done_cycle", cyc, 10);
    check("restart_count", count, 3);
    check("restart_nwr", wr_total - base, 3);
    check("restart_wr2_addr", wr_addr[base[5:0] + 6'd2], 16'h0052);
    check("restart_wr2_data", wr_data[base[5:0] + 6'd2], 8'hA3);
    $display("copy with ignored restart: done_cycle=%0d count=%0d", cyc, count);

    // Reset during WRITE of byte index 2 of 5 (cycle 9).
    poke(16'h0400, 8'h01); poke(16'h0401, 8'h02); poke(16'h0402, 8'h03);
    poke(16'h0403, 8'h04); poke(16'h0404, 8'h05);
    poke(16'h0502, 8'hEE);
    base = wr_total;
    do_start(16'h0400, 16'h0500, 16'd5, 1'b0);
    repeat (9) @(negedge clk);
    check("rstw_we_before", mem_write_en, 1);
    rstn = 1'b0;
    #1;
    check("rstw_busy",   busy,         0);
    check("rstw_we",     mem_write_en, 0);
    check("rstw_count",  count,        0);
    check("rstw_addr",   mem_addr,     0);
    check("rstw_datain", mem_datain,   0);
    @(posedge clk); #1;
    check("rstw_nwr", wr_total - base, 2);
    check("rstw_dst2_untouched", mem[16'h0502], 8'hEE);
    check("rstw_dst1", mem[16'h0501], 8'h02);
    $display("reset in WRITE byte 2: writes=%0d", wr_total - base);

    // First start after release is taken on the first rising edge.
    @(negedge clk);
    rstn = 1'b1;
    start = 1'b1; src_base = 16'h0400; dst_base = 16'h0600; length = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, cyc, bsy);
    check("postrst_done_cycle", cyc, 4);
    check("postrst_dst", mem[16'h0600], 8'h01);
    $display("copy after reset release: done_cycle=%0d", cyc);

    check("no_back_to_back_writes", consec_err, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
